// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
// Shared definitions for the data-memory port arbiter:
//   dmem_arb_state_t : beat sequencer states
//   HALF_STEP        : byte offset between the low and high halfword of a word
//   WAIT_W           : width of the fetch starvation counter
package dmem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    D_LO,
    D_HI,
    D_TAIL,
    D_ERR,
    F_BEAT,
    F_TAIL
  } dmem_arb_state_t;

  localparam logic [31:0] HALF_STEP = 32'd2;
  localparam int          WAIT_W    = 4;

endpackage

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares one 16-bit data-memory port between the execute/mem stage (32-bit
// loads/stores, split into two halfword beats) and the fetch stage (16-bit
// halfwords). Data has priority; fetch takes over after FETCH_MAX_WAIT
// consecutive lost arbitrations.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   d_req_i/d_we_i/d_addr_i/
//   d_wdata_i                    data request (held until d_gnt_o)
//   d_gnt_o, d_done_o, d_err_o,
//   d_rdata_o, d_busy_o          data grant, completion, error, load data, stall
//   f_req_i/f_addr_i             fetch request (held until f_gnt_o)
//   f_gnt_o, f_rvalid_o,
//   f_rdata_o                    fetch grant, data valid pulse, halfword
//   mem_addr_o, mem_re_o,
//   mem_we_o, mem_wdata_o,
//   mem_rdata_i                  memory port; read data arrives one cycle
//                                after mem_re_o
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int FETCH_MAX_WAIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_done_o,
  output logic        d_err_o,
  output logic [31:0] d_rdata_o,
  output logic        d_busy_o,
  input  logic        f_req_i,
  input  logic [31:0] f_addr_i,
  output logic        f_gnt_o,
  output logic        f_rvalid_o,
  output logic [15:0] f_rdata_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_re_o,
  output logic        mem_we_o,
  output logic [15:0] mem_wdata_o,
  input  logic [15:0] mem_rdata_i
);

  localparam logic [WAIT_W-1:0] MAX_WAIT = WAIT_W'(FETCH_MAX_WAIT);

  dmem_arb_state_t   state_q, state_d;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic [15:0]       lo_q;
  logic [WAIT_W-1:0] wait_q;
  logic              data_state;

  // State, latched request fields, captured low half of a load and the
  // fetch starvation counter. The counter only moves in IDLE when fetch
  // loses to data, so it never climbs past MAX_WAIT in practice; the
  // saturation guard just keeps it from wrapping.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      lo_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      if (d_gnt_o) begin
        addr_q  <= d_addr_i;
        wdata_q <= d_wdata_i;
        we_q    <= d_we_i;
      end else if (f_gnt_o) begin
        addr_q  <= f_addr_i;
        wdata_q <= '0;
        we_q    <= 1'b0;
      end
      if (state_q == D_HI && !we_q) begin
        lo_q <= mem_rdata_i;
      end
      if (f_gnt_o) begin
        wait_q <= '0;
      end else if (d_gnt_o && f_req_i && wait_q != '1) begin
        wait_q <= wait_q + WAIT_W'(1);
      end
    end
  end

  // Arbitration in IDLE and the beat sequencer. Grants depend on the
  // request inputs, but every mem_* output is decoded purely from state and
  // latched registers. Grants are gated by rst_i so that all outputs read 0
  // while reset is held, even though IDLE is the reset state.
  always_comb begin
    state_d     = state_q;
    d_gnt_o     = 1'b0;
    d_done_o    = 1'b0;
    d_err_o     = 1'b0;
    d_rdata_o   = '0;
    f_gnt_o     = 1'b0;
    f_rvalid_o  = 1'b0;
    f_rdata_o   = '0;
    mem_addr_o  = '0;
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;

    case (state_q)
      IDLE: begin
        if (rst_i) begin
          if (d_req_i && !(f_req_i && wait_q == MAX_WAIT)) begin
            d_gnt_o = 1'b1;
            state_d = d_addr_i[0] ? D_ERR : D_LO;
          end else if (f_req_i) begin
            f_gnt_o = 1'b1;
            state_d = F_BEAT;
          end
        end
      end
      D_LO: begin
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q[15:0];
        mem_we_o    = we_q;
        mem_re_o    = ~we_q;
        state_d     = D_HI;
      end
      D_HI: begin
        mem_addr_o  = addr_q + HALF_STEP;
        mem_wdata_o = wdata_q[31:16];
        mem_we_o    = we_q;
        mem_re_o    = ~we_q;
        if (we_q) begin
          d_done_o = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d  = D_TAIL;
        end
      end
      D_TAIL: begin
        d_done_o  = 1'b1;
        d_rdata_o = {mem_rdata_i, lo_q};
        state_d   = IDLE;
      end
      D_ERR: begin
        d_done_o = 1'b1;
        d_err_o  = 1'b1;
        state_d  = IDLE;
      end
      F_BEAT: begin
        mem_addr_o = addr_q;
        mem_re_o   = 1'b1;
        state_d    = F_TAIL;
      end
      F_TAIL: begin
        f_rvalid_o = 1'b1;
        f_rdata_o  = mem_rdata_i;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Execute stalls while a data request waits in IDLE or a data access is
  // still in flight; the completion cycle itself releases the stall.
  assign data_state = (state_q == D_LO) || (state_q == D_HI) ||
                      (state_q == D_TAIL) || (state_q == D_ERR);
  assign d_busy_o   = (rst_i && state_q == IDLE && d_req_i) ||
                      (data_state && !d_done_o);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
// Directed bench for dmem_port_arbiter: a per-cycle vector table covering
// store, load, address wrap, misaligned access and a lone fetch, followed by
// hand-written sequences for data/fetch contention and reset mid-store.
module tb_dmem_port_arbiter;

  logic        clk_i;
  logic        rst_i;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic        d_gnt_o;
  logic        d_done_o;
  logic        d_err_o;
  logic [31:0] d_rdata_o;
  logic        d_busy_o;
  logic        f_req_i;
  logic [31:0] f_addr_i;
  logic        f_gnt_o;
  logic        f_rvalid_o;
  logic [15:0] f_rdata_o;
  logic [31:0] mem_addr_o;
  logic        mem_re_o;
  logic        mem_we_o;
  logic [15:0] mem_wdata_o;
  logic [15:0] mem_rdata_i;

  int errors = 0;
  int checks = 0;

  dmem_port_arbiter #(.FETCH_MAX_WAIT(4)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .d_req_i    (d_req_i),
    .d_we_i     (d_we_i),
    .d_addr_i   (d_addr_i),
    .d_wdata_i  (d_wdata_i),
    .d_gnt_o    (d_gnt_o),
    .d_done_o   (d_done_o),
    .d_err_o    (d_err_o),
    .d_rdata_o  (d_rdata_o),
    .d_busy_o   (d_busy_o),
    .f_req_i    (f_req_i),
    .f_addr_i   (f_addr_i),
    .f_gnt_o    (f_gnt_o),
    .f_rvalid_o (f_rvalid_o),
    .f_rdata_o  (f_rdata_o),
    .mem_addr_o (mem_addr_o),
    .mem_re_o   (mem_re_o),
    .mem_we_o   (mem_we_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        f_req;
    logic [31:0] f_addr;
    logic [15:0] mem_rdata;
    logic        x_d_gnt;
    logic        x_d_done;
    logic        x_d_err;
    logic [31:0] x_d_rdata;
    logic        x_d_busy;
    logic        x_f_gnt;
    logic        x_f_rvalid;
    logic [15:0] x_f_rdata;
    logic [31:0] x_mem_addr;
    logic        x_mem_re;
    logic        x_mem_we;
    logic [15:0] x_mem_wdata;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];
  vec_t quiet;

  task automatic applyStimulus(input vec_t v);
    d_req_i     = v.d_req;
    d_we_i      = v.d_we;
    d_addr_i    = v.d_addr;
    d_wdata_i   = v.d_wdata;
    f_req_i     = v.f_req;
    f_addr_i    = v.f_addr;
    mem_rdata_i = v.mem_rdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkVector(input vec_t v, input string tag);
    checkOutput({tag, ".d_gnt"},     32'(d_gnt_o),     32'(v.x_d_gnt));
    checkOutput({tag, ".d_done"},    32'(d_done_o),    32'(v.x_d_done));
    checkOutput({tag, ".d_err"},     32'(d_err_o),     32'(v.x_d_err));
    checkOutput({tag, ".d_rdata"},   d_rdata_o,        v.x_d_rdata);
    checkOutput({tag, ".d_busy"},    32'(d_busy_o),    32'(v.x_d_busy));
    checkOutput({tag, ".f_gnt"},     32'(f_gnt_o),     32'(v.x_f_gnt));
    checkOutput({tag, ".f_rvalid"},  32'(f_rvalid_o),  32'(v.x_f_rvalid));
    checkOutput({tag, ".f_rdata"},   32'(f_rdata_o),   32'(v.x_f_rdata));
    checkOutput({tag, ".mem_addr"},  mem_addr_o,       v.x_mem_addr);
    checkOutput({tag, ".mem_re"},    32'(mem_re_o),    32'(v.x_mem_re));
    checkOutput({tag, ".mem_we"},    32'(mem_we_o),    32'(v.x_mem_we));
    checkOutput({tag, ".mem_wdata"}, 32'(mem_wdata_o), 32'(v.x_mem_wdata));
  endtask

  initial begin
    int  dgnts;
    bit  got_f;

    // inputs: d_req d_we d_addr d_wdata f_req f_addr mem_rdata
    // expect: d_gnt d_done d_err d_rdata d_busy f_gnt f_rvalid f_rdata mem_addr re we wdata
    quiet = '{default: '0};
    // store 0xDEADBEEF to 0x100
    vecs[0]  = '{1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0, 16'h0,
                 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 16'h0,
                 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0, 32'h100, 1'b0, 1'b1, 16'hBEEF};
    vecs[2]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 16'h0,
                 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h102, 1'b0, 1'b1, 16'hDEAD};
    // load from 0x204, memory returns 0x5678 then 0x1234
    vecs[3]  = '{1'b1, 1'b0, 32'h204, 32'h0, 1'b0, 32'h0, 16'h0,
                 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 16'h0,
                 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0, 32'h204, 1'b1, 1'b0, 16'h0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 16'h5678,
                 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0, 32'h206, 1'b1, 1'b0, 16'h0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 16'h1234,
                 1'b0, 1'b1, 1'b0, 32'h12345678, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0};
    // store at the top of the address space, high beat wraps to 0
    vecs[7]  = '{1'b1, 1'b1, 32'hFFFFFFFE, 32'hCAFEF00D, 1'b0, 32'h0, 16'h0,
                 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 16'h0,
                 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0, 32'hFFFFFFFE, 1'b0, 1'b1, 16'hF00D};
    vecs[9]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 16'h0,
                 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 16'hCAFE};
    // misaligned load at 0x101
    vecs[10] = '{1'b1, 1'b0, 32'h101, 32'h0, 1'b0, 32'h0, 16'h0,
                 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0};
    vecs[11] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 16'h0,
                 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0};
    // lone fetch at 0x40; a data request arriving mid-fetch must wait
    vecs[12] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h40, 16'h0,
                 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0};
    vecs[13] = '{1'b1, 1'b1, 32'h300, 32'h11112222, 1'b0, 32'h0, 16'h0,
                 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h40, 1'b1, 1'b0, 16'h0};
    vecs[14] = '{1'b1, 1'b1, 32'h300, 32'h11112222, 1'b0, 32'h0, 16'hABCD,
                 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 16'hABCD, 32'h0, 1'b0, 1'b0, 16'h0};
    vecs[15] = '{1'b1, 1'b1, 32'h300, 32'h11112222, 1'b0, 32'h0, 16'h0,
                 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0};
    vecs[16] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 16'h0,
                 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0, 32'h300, 1'b0, 1'b1, 16'h2222};
    vecs[17] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 16'h0,
                 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h302, 1'b0, 1'b1, 16'h1111};
    vecs[18] = quiet;

    // Reset state
    rst_i = 1'b0;
    applyStimulus(quiet);
    repeat (2) @(negedge clk_i);
    #1 checkVector(quiet, "reset");
    rst_i = 1'b1;

    // Vector table
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk_i);
      applyStimulus(vecs[i]);
      #1 checkVector(vecs[i], $sformatf("vec%0d", i));
    end

    // Contention: both requesters held; fetch wins after four data grants
    $display("[TB] contention sequence");
    @(negedge clk_i);
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h500; d_wdata_i = 32'h55556666;
    f_req_i = 1'b1; f_addr_i = 32'h40; mem_rdata_i = 16'h0;
    dgnts = 0;
    got_f = 1'b0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (f_gnt_o) begin
        got_f = 1'b1;
        break;
      end
      if (d_gnt_o) dgnts++;
      @(negedge clk_i);
    end
    checkOutput("contention.f_gnt_seen", 32'(got_f), 32'd1);
    checkOutput("contention.data_grants", 32'(dgnts), 32'd4);
    checkOutput("contention.no_dual_gnt", 32'(d_gnt_o), 32'd0);
    @(negedge clk_i);
    f_req_i = 1'b0;
    #1;
    checkOutput("contention.fbeat_addr", mem_addr_o, 32'h40);
    checkOutput("contention.fbeat_re", 32'(mem_re_o), 32'd1);
    checkOutput("contention.fbeat_no_dgnt", 32'(d_gnt_o), 32'd0);
    @(negedge clk_i);
    mem_rdata_i = 16'h7777;
    #1;
    checkOutput("contention.f_rvalid", 32'(f_rvalid_o), 32'd1);
    checkOutput("contention.f_rdata", 32'(f_rdata_o), 32'h7777);
    @(negedge clk_i);
    mem_rdata_i = 16'h0;
    #1 checkOutput("contention.data_after_fetch", 32'(d_gnt_o), 32'd1);
    @(negedge clk_i);
    d_req_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Reset asserted during the high beat of a store
    $display("[TB] reset mid-store sequence");
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h600; d_wdata_i = 32'h9999AAAA;
    f_req_i = 1'b0;
    #1 checkOutput("rst.store_gnt", 32'(d_gnt_o), 32'd1);
    @(negedge clk_i);
    d_req_i = 1'b0;
    @(negedge clk_i);
    #1;
    checkOutput("rst.dhi_we", 32'(mem_we_o), 32'd1);
    checkOutput("rst.dhi_addr", mem_addr_o, 32'h602);
    d_req_i = 1'b1;
    #1 rst_i = 1'b0;
    #1 checkVector(quiet, "rst.held");
    @(negedge clk_i);
    #1 checkVector(quiet, "rst.held2");
    rst_i = 1'b1;
    #1;
    checkOutput("rst.release_gnt", 32'(d_gnt_o), 32'd1);
    checkOutput("rst.release_busy", 32'(d_busy_o), 32'd1);
    @(negedge clk_i);
    d_req_i = 1'b0;
    #1 checkOutput("rst.after_dlo_addr", mem_addr_o, 32'h600);
    repeat (2) @(negedge clk_i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
